// File: rtl/serdes_loopback_pkg.sv
// Shared constants and types for the byte-wide serdes loopback datapath.
package serdes_loopback_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BOUNDARY_CNT = 3'd7;

  typedef logic [BYTE_W-1:0]    byte_t;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/serdes_loopback_if.sv
// Parallel byte in/out bus of the loopback, plus the serial line for observation.
interface serdes_loopback_if;
  import serdes_loopback_pkg::*;

  byte_t we;
  byte_t wy;
  logic  sd;

  modport master (output we, input wy, input sd);
  modport slave  (input we, output wy, output sd);

endinterface

// File: rtl/serdes_rx.sv
// Serial-to-parallel shifter with a hold stage and a boundary-aligned output register.
module serdes_rx
  import serdes_loopback_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  sd,
  input  logic  boundary,
  output byte_t wy
);

  // The oldest shifted bit is never read, so only the lower seven are stored.
  logic [BYTE_W-2:0] rx_sr_reg;
  logic [BYTE_W-2:0] rx_sr_next;
  byte_t             rx_hold_reg;
  byte_t             wy_reg;
  byte_t             rx_byte;

  assign rx_sr_next[0] = sd;

  genvar gi;
  generate
    for (gi = 1; gi < BYTE_W - 1; gi++) begin : g_shift
      assign rx_sr_next[gi] = rx_sr_reg[gi-1];
    end
  endgenerate

  // Byte completes with the bit currently on the line.
  assign rx_byte = {rx_sr_reg, sd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sr_reg   <= '0;
      rx_hold_reg <= '0;
      wy_reg      <= '0;
    end else begin
      rx_sr_reg <= rx_sr_next;
      if (boundary) begin
        rx_hold_reg <= rx_byte;
        wy_reg      <= rx_hold_reg;
      end
    end
  end

  assign wy = wy_reg;

endmodule

// File: rtl/serdes_tx.sv
// Byte-period counter and MSB-first parallel-to-serial shifter.
module serdes_tx
  import serdes_loopback_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  byte_t we,
  output logic  sd,
  output logic  boundary
);

  bit_cnt_t bit_cnt_reg;
  bit_cnt_t bit_cnt_next;
  byte_t    tx_sr_reg;
  byte_t    tx_sr_next;

  // Boundary edge is the one leaving count 7; both sides of the link use this strobe.
  assign boundary = (bit_cnt_reg == BOUNDARY_CNT);

  always_comb begin
    bit_cnt_next = bit_cnt_reg + 1'b1;
    tx_sr_next   = {tx_sr_reg[BYTE_W-2:0], 1'b0};
    if (boundary) begin
      tx_sr_next = we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg <= '0;
      tx_sr_reg   <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      tx_sr_reg   <= tx_sr_next;
    end
  end

  assign sd = tx_sr_reg[BYTE_W-1];

endmodule

// File: rtl/serdes_loopback.sv
// Byte serializer looped back into a deserializer; two byte-period latency.
module serdes_loopback
  import serdes_loopback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  serdes_loopback_if.slave  bus
);

  logic  sd;
  logic  boundary;
  byte_t wy;

  serdes_tx u_tx (
    .clk      (clk),
    .reset    (reset),
    .we       (bus.we),
    .sd       (sd),
    .boundary (boundary)
  );

  serdes_rx u_rx (
    .clk      (clk),
    .reset    (reset),
    .sd       (sd),
    .boundary (boundary),
    .wy       (wy)
  );

  assign bus.sd = sd;
  assign bus.wy = wy;

endmodule

// File: tb/tb_serdes_loopback.sv
// Scoreboard bench for serdes_loopback: bytes are queued on entry and popped at each boundary.
module tb_serdes_loopback;
  import serdes_loopback_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serdes_loopback_if bus ();

  serdes_loopback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  byte_t exp_q[$];
  byte_t wy_exp;
  byte_t tx_prev;

  // Two zero bytes drain out of the pipe before the first real byte after reset.
  task automatic restart_scoreboard();
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    wy_exp  = 8'h00;
    tx_prev = 8'h00;
  endtask

  // Entered just after a boundary; spends exactly one byte period.
  task automatic send_byte(input byte_t b, input bit glitch);
    byte_t ser;
    ser = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ser[7-i] = bus.sd;
      bus.we = (glitch && i < 7) ? byte_t'($urandom) : b;
      if (i == 4) begin
        checks++;
        if (bus.wy !== wy_exp) begin
          errors++;
          $display("FAIL wy_hold: got %02h expected %02h", bus.wy, wy_exp);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (ser !== tx_prev) begin
      errors++;
      $display("FAIL serial_order: got %02h expected %02h", ser, tx_prev);
    end
    tx_prev = b;
    exp_q.push_back(b);
    wy_exp = exp_q.pop_front();
    checks++;
    if (bus.wy !== wy_exp) begin
      errors++;
      $display("FAIL wy_boundary: got %02h expected %02h", bus.wy, wy_exp);
    end
    $display("byte in=%02h wy=%02h", b, bus.wy);
  endtask

  task automatic test_reset();
    bus.we = 8'hA5;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.wy !== 8'h00) begin
      errors++;
      $display("FAIL reset_wy: got %02h expected 00", bus.wy);
    end
    checks++;
    if (bus.sd !== 1'b0) begin
      errors++;
      $display("FAIL reset_sd: got %0b expected 0", bus.sd);
    end
    reset = 1'b0;
    restart_scoreboard();
    // sd must stay 0 through seven edges and go high right after the eighth.
    send_byte(8'h80, 1'b0);
    checks++;
    if (bus.sd !== 1'b1) begin
      errors++;
      $display("FAIL first_boundary_sd: got %0b expected 1", bus.sd);
    end
  endtask

  task automatic test_basic_stream();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hFF, 1'b0);
  endtask

  task automatic test_bit_order();
    send_byte(8'h80, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
  endtask

  task automatic test_glitch();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
  endtask

  task automatic test_constant();
    repeat (3) send_byte(8'hA5, 1'b0);
  endtask

  task automatic test_reset_midstream();
    send_byte(8'hC3, 1'b0);
    bus.we = 8'h77;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wy !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_wy: got %02h expected 00", bus.wy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    restart_scoreboard();
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
  endtask

  task automatic test_long_run();
    for (int i = 0; i < 256; i++) begin
      send_byte(byte_t'(i), 1'b0);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
  endtask

  initial begin
    bus.we = 8'h00;
    test_reset();
    test_basic_stream();
    test_bit_order();
    test_glitch();
    test_constant();
    test_reset_midstream();
    test_long_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serdes_loopback.md
# serdes_loopback

Byte-wide serializer/deserializer loopback used as the datapath core of the CRC16 serial link test setup. A parallel byte on `we` is captured once per 8-clock byte period and shifted out MSB-first on an internal 1-bit serial line. A deserializer reassembles the byte and presents it on `wy` after a fixed two-byte-period latency. The block has no handshake: the feeding logic must align to the byte period, which is counted from reset release.

## Interface
- Parameters: none (byte width fixed at 8, byte period fixed at 8 clocks).
- `clk` — input, 1 bit: single clock; all state changes on its rising edge.
- `reset` — input, 1 bit: asynchronous, active-high; clears all state.
- `we` — input, 8 bits: parallel data in; sampled once per byte period.
- `wy` — output, 8 bits: parallel data out; registered; stable for a full byte period.

## Operation
- `bit_cnt` (3 bits): free-running counter, 0 at reset, +1 every clock, wraps 7→0.
  - A byte boundary is every rising edge where `bit_cnt==7` before the edge.
- TX serializer:
  - `tx_sr[7:0]` loads `we` at each byte boundary; otherwise shifts left one bit per clock, inserting 0.
  - Serial line `sd = tx_sr[7]`, so bits go out MSB first.
- RX deserializer:
  - `rx_sr[7:0]` shifts left every clock, inserting `sd` at bit 0.
  - At each byte boundary, the assembled byte `{rx_sr[6:0], sd}` is copied to `rx_hold`.
- Output:
  - `wy` loads `rx_hold` at each byte boundary.
  - `wy` holds its value between boundaries.
- No framing, no bit-slip, no error reporting. Bytes pass through unmodified, in order.

## Timing
- Reset (asynchronous, while `reset`=1): `bit_cnt`, `tx_sr`, `rx_sr`, `rx_hold` and `wy` are all 0.
  - `wy` reads 8'h00 until the first real byte emerges.
- First byte boundary is the 8th rising edge after reset deassertion.
- Latency: a byte captured at boundary B appears on `wy` at boundary B+2 (16 clocks later).
  - It then stays on `wy` for exactly 8 clocks.
- After reset release, `wy` is 8'h00 for the first two boundaries.
- Throughput: one byte per 8 clocks, sustained indefinitely with no gaps.
- Input sampling:
  - `we` must be stable in the cycle ending at a boundary.
  - Changes to `we` at any other time are ignored.
- Reset mid-stream: all in-flight bytes are discarded; `wy` returns to 0 immediately (asynchronous).
  - After deassertion, counting restarts at 0.
- `we` constant across boundaries: the same byte is re-captured each period and repeated on `wy`.

## Structure
- Shared package constants:
  - `BYTE_W=8`.
  - `BIT_CNT_W=3`.
  - `BOUNDARY_CNT=3'd7`.
- Sub-modules:
  - `serdes_tx`: counter plus serializer.
  - `serdes_rx`: deserializer plus output register.
  - The two connect through `sd` and a shared boundary strobe.
- Top level `serdes_loopback` instantiates both.
- Total RTL target: 120–200 lines.

## Test plan
- Reset:
  - Assert `reset` mid-run → `wy`=8'h00 immediately, independent of clock.
  - Deassert → first boundary on the 8th edge.
- Basic stream: apply 8'h12, 8'h34, 8'hAB, 8'hFF at successive boundaries.
  - `wy` shows 00, 00, 12, 34, AB, FF at successive boundaries.
- Bit order:
  - Drive `we`=8'h80 → `sd` is 1 in the first serial cycle, then 0 for 7 cycles.
  - Drive 8'h01 → `sd` is 1 only in the 8th cycle.
- Mid-period glitch: toggle `we` on counts 0–6 while holding 8'h5A at the boundary.
  - `wy`=8'h5A two periods later.
- Reset mid-stream: assert `reset` after sending 8'hC3 but before it emerges.
  - After release, `wy` stays 00 for 2 boundaries; C3 is never output.
- Long run: stream a 256-byte file (00..FF) back-to-back.
  - Output file equals input, delayed 2 periods, with no drops or duplicates.
